shifter_pipe: RTL

Pipelined 16-bit barrel shifter wrapping four registered single-level shift stages (distances 1, 2, 4, 8) behind a valid/ready handshake. It accepts one operand, shift amount and operation per cycle, and returns the result four cycles later when the consumer is not stalling. It sits between the ALU operand-select logic (producer) and the ALU result mux (consumer), and replaces the purely combinational shifter on timing-critical paths.

---
 rtl/shifter_pipe_pkg.sv | 23 ++
 rtl/shifter_pipe_if.sv | 26 ++
 rtl/shifter_pipe_shift_stage.sv | 28 ++
 rtl/shifter_pipe.sv | 90 +++++++++
 4 files changed

// File: rtl/shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: widths, operation
// encodings and the per-stage pipeline register layout.
package shifter_pipe_pkg;

    localparam int DATA_W     = 16;
    localparam int SHAMT_W    = 4;
    localparam int NUM_STAGES = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] cnt;
        op_e                op;
    } stage_t;

endpackage

// File: rtl/shifter_pipe_if.sv
// Producer/consumer handshake bundle for the shifter pipeline.
interface shifter_pipe_if;
    import shifter_pipe_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  In;
    logic [SHAMT_W-1:0] Cnt;
    logic [1:0]         Op;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  Out;

    // The side that offers operands and takes results
    modport master (
        output in_valid, In, Cnt, Op, out_ready,
        input  in_ready, out_valid, Out
    );

    // The shifter itself
    modport slave (
        input  in_valid, In, Cnt, Op, out_ready,
        output in_ready, out_valid, Out
    );

endinterface

// File: rtl/shifter_pipe_shift_stage.sv
// One level of the barrel shifter: shifts or rotates by a fixed distance
// when enabled, otherwise passes the operand through untouched.
module shift_stage
    import shifter_pipe_pkg::*;
#(
    parameter int DIST = 1
) (
    input  logic [DATA_W-1:0] In,
    input  op_e               Op,
    input  logic              En,
    output logic [DATA_W-1:0] Out
);

    // Select the shifted/rotated form of the operand for this distance
    always_comb begin
        Out = In;
        if (En) begin
            case (Op)
                OP_ROL:  Out = (In << DIST) | (In >> (DATA_W - DIST));
                OP_SLL:  Out = In << DIST;
                OP_ROR:  Out = (In >> DIST) | (In << (DATA_W - DIST));
                OP_SRL:  Out = In >> DIST;
                default: Out = In;
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Four-stage pipelined 16-bit barrel shifter with a bubble-collapsing
// valid/ready pipeline. Stage k handles shift distance 2^(k-1).
module shifter_pipe
    import shifter_pipe_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    shifter_pipe_if.slave  bus
);

    stage_t             stageQ  [NUM_STAGES];
    stage_t             stageD  [NUM_STAGES];

    logic               srcValid [NUM_STAGES];
    logic [DATA_W-1:0]  srcData  [NUM_STAGES];
    logic [SHAMT_W-1:0] srcCnt   [NUM_STAGES];
    op_e                srcOp    [NUM_STAGES];
    logic [DATA_W-1:0]  shData   [NUM_STAGES];

    logic               adv1;
    logic               adv2;
    logic               adv3;
    logic               adv4;
    logic [NUM_STAGES-1:0] advance;

    // A stage may load when it is empty or when everything below it moves;
    // written as separate scalars so the chain back from out_ready stays a
    // plain combinational ripple.
    assign adv4 = bus.out_ready | ~stageQ[3].valid;
    assign adv3 = adv4          | ~stageQ[2].valid;
    assign adv2 = adv3          | ~stageQ[1].valid;
    assign adv1 = adv2          | ~stageQ[0].valid;
    assign advance = {adv4, adv3, adv2, adv1};

    // Source of each stage: the input ports for stage 1, the previous register otherwise
    always_comb begin
        srcValid[0] = bus.in_valid;
        srcData[0]  = bus.In;
        srcCnt[0]   = bus.Cnt;
        srcOp[0]    = op_e'(bus.Op);
        for (int k = 1; k < NUM_STAGES; k++) begin
            srcValid[k] = stageQ[k-1].valid;
            srcData[k]  = stageQ[k-1].data;
            srcCnt[k]   = stageQ[k-1].cnt;
            srcOp[k]    = stageQ[k-1].op;
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : gStage
        shift_stage #(
            .DIST (1 << g)
        ) uShift (
            .In  (srcData[g]),
            .Op  (srcOp[g]),
            .En  (srcCnt[g][g]),
            .Out (shData[g])
        );
    end

    // Next register contents: shifted data plus the carried-along control fields
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            stageD[k].valid = srcValid[k];
            stageD[k].data  = shData[k];
            stageD[k].cnt   = srcCnt[k];
            stageD[k].op    = srcOp[k];
        end
    end

    // Pipeline registers; a stage only changes when it is allowed to advance,
    // so an unaccepted result in the last stage is never disturbed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stageQ[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (advance[k]) begin
                    stageQ[k] <= stageD[k];
                end
            end
        end
    end

    assign bus.in_ready  = advance[0];
    assign bus.out_valid = stageQ[NUM_STAGES-1].valid;
    assign bus.Out       = stageQ[NUM_STAGES-1].data;

endmodule
